// File: rtl/mo_exec_pkg.sv
// mo_exec_pkg: shared constants for the microoperation executor.
//   Y*_BIT  : bit positions of the microoperation strobes inside the MI word.
//   MI_*    : microinstruction codes issued by the control FSM.
package mo_exec_pkg;

  localparam int Y1_BIT = 2;  // load operand / count, clear accumulator
  localparam int Y2_BIT = 1;  // accumulate ACC += A
  localparam int Y3_BIT = 0;  // decrement iteration counter

  localparam logic [2:0] MI_LOAD    = 3'b100;
  localparam logic [2:0] MI_ADD     = 3'b010;
  localparam logic [2:0] MI_ADD_DEC = 3'b011;

endpackage

// File: rtl/mo_exec_cnt.sv
// mo_exec_cnt: iteration counter with sticky underflow detect.
// Ports:
//   clk, reset (async, active-high)
//   load, load_val : load counter and clear underflow (wins over dec)
//   dec            : decrement; at zero the counter holds and udf is set
//   cnt, udf       : current count, sticky underflow flag
module mo_exec_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             udf
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      udf <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      udf <= 1'b0;
    end else if (dec) begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      else           udf <= 1'b1;
    end
  end

endmodule

// File: rtl/mo_exec.sv
// mo_exec: operational unit executing Y1/Y2/Y3 microoperations from a control FSM.
// Y1 loads A/CNT and clears ACC; if a previous operation was in progress the
// pre-load ACC is published on result with a one-cycle done pulse.
// Y2 accumulates ACC += A; Y3 decrements CNT. x = (CNT > 1) feeds the FSM.
// Build option: MO_EXEC_SAT_EN -- saturate ACC at all-ones on overflow
// (default: wrap modulo 2^DATA_W). ovf is set on carry-out in both modes.
// Ports:
//   clk, reset (async, active-high), en, mi[2:0], a_in, n_in
//   x, result, done, busy, ovf, udf
module mo_exec
  import mo_exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        mi,
  input  logic [DATA_W-1:0] a_in,
  input  logic [CNT_W-1:0]  n_in,
  output logic              x,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              ovf,
  output logic              udf
);

  logic              y1, y2, y3;
  logic [DATA_W-1:0] a_r, acc;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   sum;

  assign y1  = en & mi[Y1_BIT];
  assign y2  = en & mi[Y2_BIT];
  assign y3  = en & mi[Y3_BIT];
  assign sum = {1'b0, acc} + {1'b0, a_r};
  assign x   = (cnt > CNT_W'(1));

  // Y1 also gates off Y3 in the counter via load priority.
  mo_exec_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (y1),
    .load_val (n_in),
    .dec      (y3),
    .cnt      (cnt),
    .udf      (udf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r    <= '0;
      acc    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (y1) begin
        a_r  <= a_in;
        acc  <= '0;
        ovf  <= 1'b0;
        busy <= 1'b1;
        // Only an operation already under way has a result to hand back.
        if (busy) begin
          result <= acc;
          done   <= 1'b1;
        end
      end else if (y2) begin
`ifdef MO_EXEC_SAT_EN
        acc <= sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
        acc <= sum[DATA_W-1:0];
`endif
        ovf <= ovf | sum[DATA_W];
      end
    end
  end

endmodule
